// File: rtl/proc_pkg.sv
// proc_pkg: shared widths, field positions, opcodes and state encoding for the Lab 9 processor control unit.
package proc_pkg;
  localparam int PROC_OP_W = 3;
  localparam int PROC_REG_W = 3;
  localparam int PROC_IR_W = PROC_OP_W + 2 * PROC_REG_W;
  localparam int Y_LSB = 0;
  localparam int X_LSB = PROC_REG_W;
  localparam int OP_LSB = 2 * PROC_REG_W;
  localparam logic [PROC_OP_W-1:0] OP_MV = 3'b000;
  localparam logic [PROC_OP_W-1:0] OP_MVI = 3'b001;
  localparam logic [PROC_OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [PROC_OP_W-1:0] OP_SUB = 3'b011;
  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;
endpackage

// File: rtl/proc_control_fsm_if.sv
// proc_control_fsm_if: instruction/run inputs and datapath enables of the control unit.
// ILLEGAL exists only when PROC_CTRL_ILLEGAL_TRAP_EN is defined.
interface proc_control_fsm_if
  import proc_pkg::*;
#(
  parameter int IR_W = PROC_IR_W,
  parameter int REG_W = PROC_REG_W
);
  localparam int NREGS = 2 ** REG_W;
  logic RUN;
  logic [IR_W-1:0] IR;
  logic IR_WE;
  logic [NREGS-1:0] R_IN;
  logic [NREGS-1:0] R_OUT;
  logic A_IN;
  logic G_IN;
  logic G_OUT;
  logic DIN_OUT;
  logic ADDSUB;
  logic DONE;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
  logic ILLEGAL;
  modport master (input RUN, IR, output IR_WE, R_IN, R_OUT, A_IN, G_IN, G_OUT, DIN_OUT, ADDSUB, DONE, ILLEGAL);
  modport slave (output RUN, IR, input IR_WE, R_IN, R_OUT, A_IN, G_IN, G_OUT, DIN_OUT, ADDSUB, DONE, ILLEGAL);
`else
  modport master (input RUN, IR, output IR_WE, R_IN, R_OUT, A_IN, G_IN, G_OUT, DIN_OUT, ADDSUB, DONE);
  modport slave (output RUN, IR, input IR_WE, R_IN, R_OUT, A_IN, G_IN, G_OUT, DIN_OUT, ADDSUB, DONE);
`endif
endinterface

// File: rtl/reg_sel_dec.sv
// reg_sel_dec: REG_W-to-2**REG_W one-hot decoder with enable.
module reg_sel_dec #(
  parameter int REG_W = 3
) (
  input  logic i_en,
  input  logic [REG_W-1:0] i_sel,
  output logic [2**REG_W-1:0] o_dec
);
  localparam int NREGS = 2 ** REG_W;
  assign o_dec = i_en ? ({{(NREGS-1){1'b0}}, 1'b1} << i_sel) : '0;
endmodule

// File: rtl/proc_control_fsm.sv
// proc_control_fsm: T0..T3 control unit decoding III_XXX_YYY into register-file, A, G and bus-mux enables.
// Define PROC_CTRL_ILLEGAL_TRAP_EN to make 1xx opcodes latch a sticky ILLEGAL that blocks further fetches.
module proc_control_fsm
  import proc_pkg::*;
#(
  parameter int IR_W = PROC_IR_W,
  parameter int OP_W = PROC_OP_W,
  parameter int REG_W = PROC_REG_W
) (
  input logic CLK,
  input logic RESETN,
  proc_control_fsm_if.master bus
);
  localparam int NREGS = 2 ** REG_W;
  if (IR_W != OP_W + 2 * REG_W) begin : g_bad_widths
    $error("IR_W must equal OP_W + 2*REG_W");
  end
  state_t r_state, w_next;
  logic [OP_W-1:0] w_op;
  logic [REG_W-1:0] w_x, w_y;
  logic w_trap, w_ir_we, w_rin_en, w_rout_en, w_rout_y;
  logic w_a_in, w_g_in, w_g_out, w_din_out, w_addsub, w_done;
  logic [NREGS-1:0] w_r_in, w_r_out;
  assign w_op = bus.IR[OP_LSB +: OP_W];
  assign w_x = bus.IR[X_LSB +: REG_W];
  assign w_y = bus.IR[Y_LSB +: REG_W];
  always_ff @(posedge CLK) r_state <= !RESETN ? T0 : w_next;
  always_comb begin
    w_next = T0;
    w_ir_we = 1'b0;
    w_rin_en = 1'b0;
    w_rout_en = 1'b0;
    w_rout_y = 1'b0;
    w_a_in = 1'b0;
    w_g_in = 1'b0;
    w_g_out = 1'b0;
    w_din_out = 1'b0;
    w_addsub = 1'b0;
    w_done = 1'b0;
    case (r_state)
      T0: begin
        w_ir_we = bus.RUN & ~w_trap;
        w_next = w_ir_we ? T1 : T0;
      end
      T1: case (w_op)
        OP_MV: begin
          w_rout_en = 1'b1;
          w_rout_y = 1'b1;
          w_rin_en = 1'b1;
          w_done = 1'b1;
        end
        OP_MVI: begin
          w_din_out = 1'b1;
          w_rin_en = 1'b1;
          w_done = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          w_rout_en = 1'b1;
          w_a_in = 1'b1;
          w_next = T2;
        end
        default: w_done = 1'b1;
      endcase
      T2: begin
        w_rout_en = 1'b1;
        w_rout_y = 1'b1;
        w_g_in = 1'b1;
        w_addsub = bus.IR[OP_LSB];
        w_next = T3;
      end
      T3: begin
        w_g_out = 1'b1;
        w_rin_en = 1'b1;
        w_done = 1'b1;
      end
      default: w_next = T0;
    endcase
  end
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge CLK) r_illegal <= RESETN & (r_illegal | (r_state == T1 && w_op[OP_W-1]));
  assign w_trap = r_illegal;
  assign bus.ILLEGAL = RESETN & r_illegal;
`else
  assign w_trap = 1'b0;
`endif
  reg_sel_dec #(.REG_W(REG_W)) u_rin_dec (
    .i_en(RESETN & w_rin_en),
    .i_sel(w_x),
    .o_dec(w_r_in)
  );
  reg_sel_dec #(.REG_W(REG_W)) u_rout_dec (
    .i_en(RESETN & w_rout_en),
    .i_sel(w_rout_y ? w_y : w_x),
    .o_dec(w_r_out)
  );
  // Reset overrides everything combinationally, not just at the next edge.
  assign bus.IR_WE = RESETN & w_ir_we;
  assign bus.R_IN = w_r_in;
  assign bus.R_OUT = w_r_out;
  assign bus.A_IN = RESETN & w_a_in;
  assign bus.G_IN = RESETN & w_g_in;
  assign bus.G_OUT = RESETN & w_g_out;
  assign bus.DIN_OUT = RESETN & w_din_out;
  assign bus.ADDSUB = RESETN & w_addsub;
  assign bus.DONE = RESETN & w_done;
endmodule

// File: tb/tb_proc_control_fsm.sv
// tb_proc_control_fsm: cycle-by-cycle vector table plus reset/trap sequences for proc_control_fsm.
module tb_proc_control_fsm;
  import proc_pkg::*;
  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  always #5 CLK = ~CLK;
  proc_control_fsm_if bus ();
  proc_control_fsm dut (.CLK(CLK), .RESETN(RESETN), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    string nm;
    logic rstn;
    logic run;
    logic [8:0] ir;
    logic [22:0] want;
  } vec_t;
  vec_t tbl[$];
  localparam logic [8:0] MVI_R2 = 9'b001_010_000;
  localparam logic [8:0] MV_R1R5 = 9'b000_001_101;
  localparam logic [8:0] ADD_R0R3 = 9'b010_000_011;
  localparam logic [8:0] SUB_R0R3 = 9'b011_000_011;
  localparam logic [8:0] MV_R3R3 = 9'b000_011_011;
  localparam logic [8:0] UNDEF = 9'b100_000_000;
  localparam logic [22:0] Z = '0;
  function automatic logic [22:0] e(input logic we, input logic [7:0] rin, input logic [7:0] rout,
                                    input logic ain, input logic gin, input logic gout,
                                    input logic din, input logic as, input logic dn);
    return {we, rin, rout, ain, gin, gout, din, as, dn};
  endfunction
  localparam logic [22:0] FETCH = 23'h400000;
  task automatic step(input string nm, input logic rstn, input logic run, input logic [8:0] ir,
                      input logic [22:0] want);
    logic [22:0] act;
    @(posedge CLK);
    #1;
    RESETN = rstn;
    bus.RUN = run;
    bus.IR = ir;
    #3;
    act = {bus.IR_WE, bus.R_IN, bus.R_OUT, bus.A_IN, bus.G_IN, bus.G_OUT, bus.DIN_OUT, bus.ADDSUB, bus.DONE};
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got {we,rin,rout,ain,gin,gout,din,as,done}=%b_%h_%h_%b%b%b%b%b%b want %b_%h_%h_%b%b%b%b%b%b",
               nm, act[22], act[21:14], act[13:6], act[5], act[4], act[3], act[2], act[1], act[0],
               want[22], want[21:14], want[13:6], want[5], want[4], want[3], want[2], want[1], want[0]);
    end
    n_chk++;
    if ($countones({bus.R_OUT, bus.G_OUT, bus.DIN_OUT}) > 1) begin
      n_fail++;
      $display("FAIL %s bus_drivers: got %0d drivers want <=1", nm,
               $countones({bus.R_OUT, bus.G_OUT, bus.DIN_OUT}));
    end
  endtask
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
  task automatic chk_ill(input string nm, input logic want);
    n_chk++;
    if (bus.ILLEGAL !== want) begin
      n_fail++;
      $display("FAIL %s illegal: got %b want %b", nm, bus.ILLEGAL, want);
    end
  endtask
`endif
  initial begin
    bus.RUN = 1'b0;
    bus.IR = '0;
    tbl.push_back('{"rst0", 1'b0, 1'b1, MVI_R2, Z});
    tbl.push_back('{"rst1", 1'b0, 1'b1, MVI_R2, Z});
    for (int i = 0; i < 5; i++) tbl.push_back('{"idle", 1'b1, 1'b0, MVI_R2, Z});
    tbl.push_back('{"mvi_t0", 1'b1, 1'b1, MVI_R2, FETCH});
    tbl.push_back('{"mvi_t1", 1'b1, 1'b0, MVI_R2, e(0, 8'h04, 8'h00, 0, 0, 0, 1, 0, 1)});
    tbl.push_back('{"mvi_done_low", 1'b1, 1'b0, MVI_R2, Z});
    tbl.push_back('{"mv_t0", 1'b1, 1'b1, MV_R1R5, FETCH});
    tbl.push_back('{"mv_t1", 1'b1, 1'b0, MV_R1R5, e(0, 8'h02, 8'h20, 0, 0, 0, 0, 0, 1)});
    tbl.push_back('{"add_t0", 1'b1, 1'b1, ADD_R0R3, FETCH});
    tbl.push_back('{"add_t1", 1'b1, 1'b1, ADD_R0R3, e(0, 8'h00, 8'h01, 1, 0, 0, 0, 0, 0)});
    tbl.push_back('{"add_t2", 1'b1, 1'b1, ADD_R0R3, e(0, 8'h00, 8'h08, 0, 1, 0, 0, 0, 0)});
    tbl.push_back('{"add_t3", 1'b1, 1'b1, ADD_R0R3, e(0, 8'h01, 8'h00, 0, 0, 1, 0, 0, 1)});
    tbl.push_back('{"sub_t0_b2b", 1'b1, 1'b1, SUB_R0R3, FETCH});
    tbl.push_back('{"sub_t1", 1'b1, 1'b0, SUB_R0R3, e(0, 8'h00, 8'h01, 1, 0, 0, 0, 0, 0)});
    tbl.push_back('{"sub_t2", 1'b1, 1'b0, SUB_R0R3, e(0, 8'h00, 8'h08, 0, 1, 0, 0, 1, 0)});
    tbl.push_back('{"sub_t3", 1'b1, 1'b0, SUB_R0R3, e(0, 8'h01, 8'h00, 0, 0, 1, 0, 0, 1)});
    tbl.push_back('{"sub_after", 1'b1, 1'b0, SUB_R0R3, Z});
    tbl.push_back('{"mv_same_t0", 1'b1, 1'b1, MV_R3R3, FETCH});
    tbl.push_back('{"mv_same_t1", 1'b1, 1'b0, MV_R3R3, e(0, 8'h08, 8'h08, 0, 0, 0, 0, 0, 1)});
    tbl.push_back('{"undef_t0", 1'b1, 1'b1, UNDEF, FETCH});
    tbl.push_back('{"undef_t1", 1'b1, 1'b0, UNDEF, e(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1)});
    tbl.push_back('{"undef_after", 1'b1, 1'b0, UNDEF, Z});
    foreach (tbl[i]) step(tbl[i].nm, tbl[i].rstn, tbl[i].run, tbl[i].ir, tbl[i].want);
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    chk_ill("trap_set", 1'b1);
    step("trap_run_blocked", 1'b1, 1'b1, MV_R1R5, Z);
    chk_ill("trap_sticky", 1'b1);
    step("trap_still_t0", 1'b1, 1'b1, MV_R1R5, Z);
    step("trap_rst", 1'b0, 1'b1, MV_R1R5, Z);
    chk_ill("trap_rst_forced", 1'b0);
`endif
    step("rst_pre_sub", 1'b0, 1'b0, SUB_R0R3, Z);
    step("idle_pre_sub", 1'b1, 1'b0, SUB_R0R3, Z);
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    chk_ill("trap_cleared", 1'b0);
`endif
    step("rsub_t0", 1'b1, 1'b1, SUB_R0R3, FETCH);
    step("rsub_t1", 1'b1, 1'b0, SUB_R0R3, e(0, 8'h00, 8'h01, 1, 0, 0, 0, 0, 0));
    step("rsub_t2_rst", 1'b0, 1'b0, SUB_R0R3, Z);
    step("rsub_post_rst", 1'b1, 1'b0, SUB_R0R3, Z);
    step("rsub_post_rst2", 1'b1, 1'b0, SUB_R0R3, Z);
    step("recover_t0", 1'b1, 1'b1, ADD_R0R3, FETCH);
    step("recover_t1", 1'b1, 1'b0, ADD_R0R3, e(0, 8'h00, 8'h01, 1, 0, 0, 0, 0, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/proc_control_fsm.md
Name: proc_control_fsm

Overview:
- Control unit for the Lab 9 simple processor, and the reader of the 9-bit instruction register.
- Asserts IR_WE in T0 to load the IR, which captures on the falling edge of CLK.
- Decodes the latched word (format III_XXX_YYY) on later rising edges and drives the register-file, accumulator (A), G and bus-mux enables across time-steps T0–T3.
- Asserts DONE when the instruction completes.

Parameters:
- IR_W, 9, instruction width. Must equal OP_W + 2*REG_W.
- OP_W, 3, opcode field width, IR[8:6].
- REG_W, 3, register-select field width (X = IR[5:3], Y = IR[2:0]). NREGS = 2**REG_W.

Ports:
- CLK  in  1  system clock. FSM updates on the rising edge.
- RESETN  in  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- RUN  in  1  start request. Sampled only in T0.
- IR  in  IR_W  instruction-register contents.
- IR_WE  out  1  instruction-register load enable.
- R_IN  out  NREGS  one-hot register-file write enables.
- R_OUT  out  NREGS  one-hot register-to-bus drive enables.
- A_IN  out  1  accumulator (A) load.
- G_IN  out  1  G (ALU result) load.
- G_OUT  out  1  G drives bus.
- DIN_OUT  out  1  DIN drives bus.
- ADDSUB  out  1  ALU function: 0 add, 1 subtract.
- DONE  out  1  instruction complete, one cycle wide.

Behaviour:
- Single clock domain; reset is synchronous and active-low.
- States: T0 (fetch/idle), T1, T2, T3. 2-bit registered state.
- Reset: at the next rising edge with RESETN=0, state becomes T0.
  - While RESETN=0, all outputs are forced to 0.
  - Reset value of every output is 0.
- Outputs are combinational from state, IR and RUN. No output is registered.
- T0:
  - IR_WE = RUN.
  - RUN=1 -> next state T1; otherwise stay in T0.
  - IR loads on the falling edge inside T0 and is stable for T1.
- Opcodes:
  - 000 mv Rx,Ry: T1 asserts R_OUT[Y], R_IN[X], DONE; then T0.
  - 001 mvi Rx,#D: T1 asserts DIN_OUT, R_IN[X], DONE; then T0. The immediate comes from the following DIN word.
  - 010 add / 011 sub:
    - T1: R_OUT[X], A_IN.
    - T2: R_OUT[Y], G_IN, ADDSUB = IR[6].
    - T3: G_OUT, R_IN[X], DONE; then T0.
  - 1xx (undefined): T1 asserts DONE only; then T0.
- Latency: mv/mvi/undefined take 2 cycles from RUN sampled to T0 re-entry; add/sub take 4.
- DONE is high exactly one cycle per instruction.
- RUN is ignored in T1–T3. Back-to-back RUN is allowed: RUN=1 in the T0 that follows DONE starts the next fetch.
- X == Y is legal: R_OUT and R_IN select the same register. No special case.
- At most one bus driver (R_OUT bit, G_OUT, DIN_OUT) is asserted in any cycle. Bench asserts this.
- Reset mid-operation (any of T1–T3): next edge goes to T0, outputs go to 0 immediately, no DONE, no partial R_IN.
- Outside the listed states and conditions, all outputs are 0. An unreachable state encoding recovers to T0.

Optional Feature:
- Macro: PROC_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port ILLEGAL (1 bit, reset 0).
  - An 1xx opcode in T1 sets ILLEGAL; it is sticky.
  - While ILLEGAL=1, the FSM stays in T0 with IR_WE forced to 0, and DONE is still pulsed for the offending instruction.
  - ILLEGAL clears only on reset.
- Undefined: no ILLEGAL port; 1xx executes as a NOP (DONE only).

Decomposition:
- Shared package proc_pkg:
  - opcode constants OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011.
  - state typedef/encoding T0..T3.
  - field-slice constants for III/XXX/YYY.
- One sub-module: reg_sel_dec, a REG_W-to-NREGS one-hot decoder with an enable input. Instantiated twice (X -> R_IN, Y/X -> R_OUT via mux).

Test Plan:
- Reset/idle: RESETN=0 for 2 cycles, then RUN=0 for 5 cycles -> all outputs 0, IR_WE never asserted.
- mvi R2: IR=9'b001_010_000, RUN=1 in T0 -> T0 IR_WE=1; T1 DIN_OUT=1, R_IN=8'b0000_0100, DONE=1; next cycle T0 with DONE=0.
- mv R1,R5: IR=9'b000_001_101 -> T1 R_OUT=8'b0010_0000, R_IN=8'b0000_0010, DONE=1.
- add R0,R3: IR=9'b010_000_011 -> T1 R_OUT=8'h01 with A_IN; T2 R_OUT=8'h08 with G_IN and ADDSUB=0; T3 G_OUT, R_IN=8'h01, DONE. Repeat with sub (IR=9'b011_000_011) -> ADDSUB=1 in T2.
- Reset mid-sub: RESETN=0 during T2 -> same cycle all outputs 0; next edge T0; no DONE, R_IN never asserted.
- Undefined: IR=9'b100_000_000 -> T1 DONE=1 only.
  - With PROC_CTRL_ILLEGAL_TRAP_EN: ILLEGAL=1; a subsequent RUN=1 gives IR_WE=0 until reset.
